bus_uart_tx_slave: RTL

- Memory-mapped UART transmitter. It is a bus responder placed behind the interconnect's chip-select, in the 0x0000_22xx address slot.
- The CPU writes bytes into a small TX FIFO. The block serialises them 8N1 on `tx` at a programmable bit period.
- Read data is returned combinationally, so it fits the interconnect's single-cycle read mux.

---
 rtl/bus_uart_tx_slave.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/bus_uart_tx_slave.sv
// Memory-mapped 8N1 UART transmitter: CPU pushes bytes into a small FIFO,
// a four-state shifter drains them on tx at a per-frame latched bit period.
module bus_uart_tx_slave #(
  parameter int FIFO_DEPTH  = 4,
  parameter int DEFAULT_DIV = 10416
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        we,
  input  logic [7:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic [7:0] A_TXDATA = 8'h00;
  localparam logic [7:0] A_STATUS = 8'h04;
  localparam logic [7:0] A_BAUD   = 8'h08;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  // bus decode
  logic wr_en, push_req, ovf_clr, baud_wr;
  assign wr_en    = cs & we;
  assign push_req = wr_en & (addr == A_TXDATA);
  assign ovf_clr  = wr_en & (addr == A_STATUS) & wdata[3];
  assign baud_wr  = wr_en & (addr == A_BAUD);

  logic unused_wdata;
  assign unused_wdata = ^wdata[31:16];

  // FIFO state
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   bauddiv_q, bauddiv_d;
  logic          full, empty, pop, push_acc;

  // shifter state
  state_e        state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [15:0]   baudcnt_q, baudcnt_d;
  logic [15:0]   div_q, div_d;
  logic          tx_q, tx_d;
  logic          baud_end;

  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  // A full FIFO still accepts a push when the shifter pops in the same cycle.
  assign push_acc = push_req & (~full | pop);

  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    bauddiv_d = bauddiv_q;
    if (push_acc) wptr_d = wptr_q + AW'(1);
    if (pop)      rptr_d = rptr_q + AW'(1);
    count_d = count_q + CW'(push_acc) - CW'(pop);
    if (push_req & full & ~pop) ovf_d = 1'b1;
    else if (ovf_clr)           ovf_d = 1'b0;
    if (baud_wr) bauddiv_d = wdata[15:0];
  end

  always_ff @(posedge clk) begin
    if (push_acc) mem_q[wptr_q] <= wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      bauddiv_q <= 16'(DEFAULT_DIV);
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      bauddiv_q <= bauddiv_d;
    end
  end

  assign baud_end = (baudcnt_q == div_q - 16'd1);

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bitcnt_d  = bitcnt_q;
    baudcnt_d = baudcnt_q;
    div_d     = div_q;
    pop       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          shift_d   = mem_q[rptr_q];
          div_d     = (bauddiv_q == 16'd0) ? 16'd1 : bauddiv_q;
          baudcnt_d = '0;
          bitcnt_d  = '0;
          state_d   = START;
        end
      end
      START: begin
        if (baud_end) begin
          baudcnt_d = '0;
          state_d   = DATA;
        end else begin
          baudcnt_d = baudcnt_q + 16'd1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baudcnt_d = '0;
          shift_d   = {1'b0, shift_q[7:1]};
          if (bitcnt_q == 3'd7) begin
            bitcnt_d = '0;
            state_d  = STOP;
          end else begin
            bitcnt_d = bitcnt_q + 3'd1;
          end
        end else begin
          baudcnt_d = baudcnt_q + 16'd1;
        end
      end
      STOP: begin
        if (baud_end) begin
          baudcnt_d = '0;
          state_d   = IDLE;
        end else begin
          baudcnt_d = baudcnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // tx is registered from next-state so the line never glitches
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bitcnt_q  <= '0;
      baudcnt_q <= '0;
      div_q     <= 16'd1;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bitcnt_q  <= bitcnt_d;
      baudcnt_q <= baudcnt_d;
      div_q     <= div_d;
      tx_q      <= tx_d;
    end
  end

  assign tx = tx_q;

  logic       busy;
  logic [3:0] cnt4;
  assign busy = (state_q != IDLE);
  assign cnt4 = 4'(count_q);

  always_comb begin
    rdata = '0;
    if (cs) begin
      unique case (addr)
        A_STATUS: rdata = {24'd0, cnt4, ovf_q, busy, empty, full};
        A_BAUD:   rdata = {16'd0, bauddiv_q};
        default:  rdata = '0;
      endcase
    end
  end

endmodule
